// File: rtl/sys_defs_pkg.sv
// rtl/sys_defs_pkg.sv - shared ROB entry type, default ROB depth and the ZERO_REG macro
`define ZERO_REG 5'd0

package sys_defs;

  localparam int ROB_SZ = 8;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [63:0] value;
    logic [4:0]  dest_reg;
    logic [63:0] dest_addr;
    logic        wr_mem;
    logic [1:0]  mem_size;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping ROB pointer with increment enable, sync reset and clear
module rob_ptr #(
  parameter int TAG_W = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [TAG_W-1:0] o_ptr
);

  logic [TAG_W-1:0] r_ptr;

  // Power-of-two depth, so natural overflow is the modulo wrap.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer: dispatch alloc, CDB completion, in-order retire
// Optional feature macro: ROB_SQUASH_EN adds the squash input (full flush on the next edge).
module reorder_buffer
  import sys_defs::*;
#(
  parameter  int ROB_SIZE = ROB_SZ,
  localparam int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  ROB_ENTRY         dispatch_entry,
  output logic             rob_full,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [63:0]      cdb_value,
  input  logic [63:0]      cdb_dest_addr,
`ifdef ROB_SQUASH_EN
  input  logic             squash,
`endif
  output ROB_ENTRY         head_entry,
  output logic             head_ready,
  output logic [TAG_W-1:0] commit_rob_tag
);

  ROB_ENTRY         r_entries [ROB_SIZE];
  logic [TAG_W:0]   r_count;
  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  logic             w_alloc;
  logic             w_retire;
  logic             w_cdb_hit;
  logic             w_squash;
  ROB_ENTRY         w_new;

`ifdef ROB_SQUASH_EN
  assign w_squash = squash;
`else
  assign w_squash = 1'b0;
`endif

  // Full comes from the registered count only: a same-cycle retire never frees a slot.
  assign rob_full   = (r_count == (TAG_W + 1)'(ROB_SIZE));
  assign w_alloc    = dispatch_valid && !rob_full;
  assign head_entry = r_entries[w_head];
  assign head_ready = head_entry.valid && head_entry.ready;
  assign w_retire   = head_ready;
  assign w_cdb_hit  = cdb_valid && r_entries[cdb_tag].valid;

  assign dispatch_tag   = w_tail;
  assign commit_rob_tag = w_head;

  always_comb begin
    w_new       = dispatch_entry;
    w_new.valid = 1'b1;
    w_new.ready = 1'b0;
  end

  rob_ptr #(.TAG_W(TAG_W)) u_head_ptr (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_squash),
    .i_inc   (w_retire),
    .o_ptr   (w_head)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail_ptr (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_squash),
    .i_inc   (w_alloc),
    .o_ptr   (w_tail)
  );

  // Retire is applied after the CDB write so a stray re-broadcast cannot resurrect the head.
  always_ff @(posedge clock) begin
    if (reset || w_squash) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_cdb_hit) begin
        r_entries[cdb_tag].ready     <= 1'b1;
        r_entries[cdb_tag].value     <= cdb_value;
        r_entries[cdb_tag].dest_addr <= cdb_dest_addr;
      end
      if (w_retire) begin
        r_entries[w_head].valid <= 1'b0;
        r_entries[w_head].ready <= 1'b0;
      end
      if (w_alloc) begin
        r_entries[w_tail] <= w_new;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_squash) begin
      r_count <= '0;
    end else if (w_alloc && !w_retire) begin
      r_count <= r_count + 1'b1;
    end else if (!w_alloc && w_retire) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
